// File: rtl/ball_motion_ctrl_pkg.sv
// Shared definitions for the breakout ball path: FSM state encoding, default
// playfield/serve constants and a saturating speed helper. Imported by the
// ball controller, the renderer and the collision detector.
package ball_motion_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_PAUSED = 2'd2,
        ST_MISS   = 2'd3
    } ball_state_t;

    localparam int DEF_POS_W       = 10;
    localparam int DEF_BALL_R      = 8;
    localparam int DEF_LEFT_EDGE   = 0;
    localparam int DEF_RIGHT_EDGE  = 640;
    localparam int DEF_TOP_EDGE    = 0;
    localparam int DEF_BOTTOM_EDGE = 480;
    localparam int DEF_START_X     = 320;
    localparam int DEF_START_Y     = 400;
    localparam int DEF_DX_BASE     = 5;
    localparam int DEF_DY_BASE     = 10;

    function automatic logic [2:0] speed_inc(input logic [2:0] s);
        return (s == 3'd7) ? s : s + 3'd1;
    endfunction

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Ball controller bus: frame sync, launch/pause, collision inputs and the
// registered ball state presented to the renderer.
interface ball_motion_ctrl_if #(
    parameter int POS_W = 10
);
    logic             vsync;
    logic             start;
    logic             pause;
    logic             h_collision;
    logic             v_collision;
    logic [POS_W-1:0] ball_x;
    logic [POS_W-1:0] ball_y;
    logic             dir_x;
    logic             dir_y;
    logic             moving;
    logic             miss;
    logic [2:0]       speed;

    modport master (
        output vsync, start, pause, h_collision, v_collision,
        input  ball_x, ball_y, dir_x, dir_y, moving, miss, speed
    );

    modport slave (
        input  vsync, start, pause, h_collision, v_collision,
        output ball_x, ball_y, dir_x, dir_y, moving, miss, speed
    );
endinterface

// File: rtl/ball_axis_step.sv
// One axis of ball motion for a single frame: optional direction flip,
// candidate step, clamp against [MIN_P+BALL_R, MAX_P-BALL_R] with bounce.
// hit_max_o flags a clamp at the max bound while moving positive.
module ball_axis_step #(
    parameter int POS_W  = 10,
    parameter int MIN_P  = 0,
    parameter int MAX_P  = 640,
    parameter int BALL_R = 8
) (
    input  logic [POS_W-1:0] pos_i,
    input  logic             dir_i,
    input  logic             flip_i,
    input  logic [POS_W:0]   step_i,
    output logic [POS_W-1:0] pos_o,
    output logic             dir_o,
    output logic             hit_max_o
);
    localparam logic [POS_W:0] LIM_HI = (POS_W+1)'(MAX_P - BALL_R);
    localparam logic [POS_W:0] LIM_LO = (POS_W+1)'(MIN_P + BALL_R);

    logic             dir_f;
    logic [POS_W:0]   inc;
    logic [POS_W-1:0] dec;

    assign dir_f = dir_i ^ flip_i;
    assign inc   = {1'b0, pos_i} + step_i;
    assign dec   = pos_i - step_i[POS_W-1:0];

    // Wall clamp wins over the flip result; the low-side test avoids underflow
    always_comb begin
        pos_o     = pos_i;
        dir_o     = dir_f;
        hit_max_o = 1'b0;
        if (dir_f) begin
            if (inc >= LIM_HI) begin
                pos_o     = LIM_HI[POS_W-1:0];
                dir_o     = 1'b0;
                hit_max_o = 1'b1;
            end else begin
                pos_o = inc[POS_W-1:0];
            end
        end else begin
            if ({1'b0, pos_i} <= LIM_LO + step_i) begin
                pos_o = LIM_LO[POS_W-1:0];
                dir_o = 1'b1;
            end else begin
                pos_o = dec;
            end
        end
    end
endmodule

// File: rtl/ball_motion_ctrl.sv
// Breakout ball kinematics engine (pxl_clk domain). Steps the ball once per
// vsync rising edge, applies latched collision flips, clamps at the walls and
// runs the serve/miss cycle. Optional paddle-hit speed-up: BALL_SPEEDUP_EN.
//
//   state     | meaning
//   ----------+-------------------------------------------
//   ST_IDLE   | ball parked at serve position, wait start
//   ST_MOVE   | ball steps on each frame tick
//   ST_PAUSED | motion frozen, collisions still latched
//   ST_MISS   | one-cycle miss pulse, then back to serve
module ball_motion_ctrl
    import ball_motion_ctrl_pkg::*;
#(
    parameter int POS_W         = DEF_POS_W,
    parameter int BALL_R        = DEF_BALL_R,
    parameter int LEFT_EDGE     = DEF_LEFT_EDGE,
    parameter int RIGHT_EDGE    = DEF_RIGHT_EDGE,
    parameter int TOP_EDGE      = DEF_TOP_EDGE,
    parameter int BOTTOM_EDGE   = DEF_BOTTOM_EDGE,
    parameter int START_X       = DEF_START_X,
    parameter int START_Y       = DEF_START_Y,
    parameter int DX_BASE       = DEF_DX_BASE,
    parameter int DY_BASE       = DEF_DY_BASE,
    parameter int SERVE_UP      = 0,
    parameter int HITS_PER_STEP = 4
) (
    input logic               pxl_clk,
    input logic               reset_n,
    ball_motion_ctrl_if.slave bus
);
    localparam logic [POS_W-1:0] SERVE_X  = POS_W'(START_X);
    localparam logic [POS_W-1:0] SERVE_Y  = POS_W'(START_Y);
    localparam logic             SERVE_DY = (SERVE_UP == 0);

    ball_state_t      state_q, state_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic             dx_q, dx_d, dy_q, dy_d;
    logic             h_pend_q, h_pend_d, v_pend_q, v_pend_d;
    logic             vsync_q, moving_q, moving_d, miss_q, miss_d;
    logic [2:0]       speed;
    logic             tick, h_flip, v_flip;
    logic [POS_W:0]   step_x, step_y;
    logic [POS_W-1:0] x_nxt, y_nxt;
    logic             dx_nxt, dy_nxt, y_hit_max, x_hit_max_unused;

    assign tick   = bus.vsync & ~vsync_q;
    assign h_flip = h_pend_q | bus.h_collision;
    assign v_flip = v_pend_q | bus.v_collision;
    assign step_x = (POS_W+1)'(DX_BASE) + {{(POS_W-2){1'b0}}, speed};
    assign step_y = (POS_W+1)'(DY_BASE) + {{(POS_W-3){1'b0}}, speed, 1'b0};

`ifdef BALL_SPEEDUP_EN
    localparam int HIT_CNT_W = 4;

    logic [2:0]           speed_q, speed_d;
    logic [HIT_CNT_W-1:0] hits_q, hits_d, hits_inc;
    logic                 paddle_hit;

    assign speed      = speed_q;
    assign hits_inc   = hits_q + 1'b1;
    assign paddle_hit = (state_q == ST_MOVE) & tick & v_flip & dy_q;

    // Count paddle hits (downward ball flipped up) and bump speed per group
    always_comb begin
        speed_d = speed_q;
        hits_d  = hits_q;
        if (state_q == ST_MISS) begin
            speed_d = 3'd0;
            hits_d  = '0;
        end else if (paddle_hit) begin
            if (hits_inc == HIT_CNT_W'(HITS_PER_STEP)) begin
                speed_d = speed_inc(speed_q);
                hits_d  = '0;
            end else begin
                hits_d = hits_inc;
            end
        end
    end

    // Speed level and hit counter registers
    always_ff @(posedge pxl_clk or negedge reset_n) begin
        if (!reset_n) begin
            speed_q <= 3'd0;
            hits_q  <= '0;
        end else begin
            speed_q <= speed_d;
            hits_q  <= hits_d;
        end
    end
`else
    localparam int unused_hits_per_step = HITS_PER_STEP;
    assign speed = 3'd0;
`endif

    ball_axis_step #(
        .POS_W (POS_W), .MIN_P (LEFT_EDGE), .MAX_P (RIGHT_EDGE), .BALL_R (BALL_R)
    ) u_axis_x (
        .pos_i (x_q), .dir_i (dx_q), .flip_i (h_flip), .step_i (step_x),
        .pos_o (x_nxt), .dir_o (dx_nxt), .hit_max_o (x_hit_max_unused)
    );

    ball_axis_step #(
        .POS_W (POS_W), .MIN_P (TOP_EDGE), .MAX_P (BOTTOM_EDGE), .BALL_R (BALL_R)
    ) u_axis_y (
        .pos_i (y_q), .dir_i (dy_q), .flip_i (v_flip), .step_i (step_y),
        .pos_o (y_nxt), .dir_o (dy_nxt), .hit_max_o (y_hit_max)
    );

    // Next-state, motion update and pending-flag bookkeeping
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        h_pend_d = h_flip;
        v_pend_d = v_flip;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                if (tick) begin
                    x_d      = x_nxt;
                    y_d      = y_nxt;
                    dx_d     = dx_nxt;
                    dy_d     = dy_nxt;
                    h_pend_d = 1'b0;
                    v_pend_d = 1'b0;
                    if (y_hit_max) state_d = ST_MISS;
                end else if (bus.pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (!bus.pause) state_d = ST_MOVE;
            end
            ST_MISS: begin
                x_d      = SERVE_X;
                y_d      = SERVE_Y;
                dx_d     = 1'b1;
                dy_d     = SERVE_DY;
                h_pend_d = 1'b0;
                v_pend_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        moving_d = (state_d == ST_MOVE);
        miss_d   = (state_d == ST_MISS);
    end

    // State, position and flag registers
    always_ff @(posedge pxl_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            x_q      <= SERVE_X;
            y_q      <= SERVE_Y;
            dx_q     <= 1'b1;
            dy_q     <= SERVE_DY;
            h_pend_q <= 1'b0;
            v_pend_q <= 1'b0;
            vsync_q  <= 1'b1;
            moving_q <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            h_pend_q <= h_pend_d;
            v_pend_q <= v_pend_d;
            vsync_q  <= bus.vsync;
            moving_q <= moving_d;
            miss_q   <= miss_d;
        end
    end

    assign bus.ball_x = x_q;
    assign bus.ball_y = y_q;
    assign bus.dir_x  = dx_q;
    assign bus.dir_y  = dy_q;
    assign bus.moving = moving_q;
    assign bus.miss   = miss_q;
    assign bus.speed  = speed;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: the driver pushes hand-computed
// expectations per frame tick or probe; the monitor pops and compares.
module tb_ball_motion_ctrl;

    localparam logic [6:0] M_X = 7'h01, M_Y = 7'h02, M_DX = 7'h04, M_DY = 7'h08;
    localparam logic [6:0] M_MV = 7'h10, M_MS = 7'h20, M_SP = 7'h40, ALL = 7'h7f;

    typedef struct packed {
        logic [15:0] id;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        dx;
        logic        dy;
        logic        mv;
        logic        ms;
        logic [2:0]  spd;
        logic [6:0]  m;
    } exp_t;

    logic pxl_clk;
    logic reset_n;
    logic probe;
    logic vs_prev;
    logic tick_seen;
    int   checks;
    int   errors;
    exp_t sb[$];

    ball_motion_ctrl_if #(.POS_W(10)) bus ();

    ball_motion_ctrl dut (
        .pxl_clk (pxl_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial pxl_clk = 1'b0;
    always #5 pxl_clk = ~pxl_clk;

    function automatic exp_t mk(input int id, input int x, input int y, input int dx,
                                input int dy, input int mv, input int ms, input int spd,
                                input logic [6:0] m);
        exp_t e;
        e.id  = 16'(id);
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.dx  = 1'(dx);
        e.dy  = 1'(dy);
        e.mv  = 1'(mv);
        e.ms  = 1'(ms);
        e.spd = 3'(spd);
        e.m   = m;
        return e;
    endfunction

    task automatic cmp(input string nm, input int id, input logic [9:0] got, input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %0d, expected %0d", nm, id, got, want);
        end
    endtask

    // Monitor: a frame tick or a probe request means the DUT presents a result
    initial begin : monitor
        exp_t e;
        vs_prev   = 1'b1;
        tick_seen = 1'b0;
        forever begin
            @(posedge pxl_clk);
            tick_seen = reset_n && bus.vsync && !vs_prev;
            vs_prev   = reset_n ? bus.vsync : 1'b1;
            @(negedge pxl_clk);
            if (tick_seen || probe) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got output event, expected none");
                end else begin
                    e = sb.pop_front();
                    if (e.m[0]) cmp("ball_x", int'(e.id), bus.ball_x, e.x);
                    if (e.m[1]) cmp("ball_y", int'(e.id), bus.ball_y, e.y);
                    if (e.m[2]) cmp("dir_x",  int'(e.id), 10'(bus.dir_x), 10'(e.dx));
                    if (e.m[3]) cmp("dir_y",  int'(e.id), 10'(bus.dir_y), 10'(e.dy));
                    if (e.m[4]) cmp("moving", int'(e.id), 10'(bus.moving), 10'(e.mv));
                    if (e.m[5]) cmp("miss",   int'(e.id), 10'(bus.miss), 10'(e.ms));
                    if (e.m[6]) cmp("speed",  int'(e.id), 10'(bus.speed), 10'(e.spd));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic frame(input logic hc, input logic vc, input logic pz, input exp_t e);
        @(posedge pxl_clk); #1;
        sb.push_back(e);
        bus.vsync       = 1'b1;
        bus.h_collision = hc;
        bus.v_collision = vc;
        bus.pause       = pz;
        @(posedge pxl_clk); #1;
        bus.h_collision = 1'b0;
        bus.v_collision = 1'b0;
        repeat (2) @(posedge pxl_clk);
        #1 bus.vsync = 1'b0;
        repeat (2) @(posedge pxl_clk);
    endtask

    task automatic probe_chk(input exp_t e);
        @(posedge pxl_clk); #1;
        sb.push_back(e);
        probe = 1'b1;
        @(negedge pxl_clk); #1;
        probe = 1'b0;
    endtask

    task automatic pulse_coll(input logic hc, input logic vc);
        @(posedge pxl_clk); #1;
        bus.h_collision = hc;
        bus.v_collision = vc;
        @(posedge pxl_clk); #1;
        bus.h_collision = 1'b0;
        bus.v_collision = 1'b0;
    endtask

    task automatic launch();
        @(posedge pxl_clk); #1 bus.start = 1'b1;
        @(posedge pxl_clk); #1 bus.start = 1'b0;
    endtask

    // Reset asserted between clock edges; outputs must change before the next edge
    task automatic mid_reset(input int id);
        @(posedge pxl_clk); #1;
        reset_n = 1'b0;
        sb.push_back(mk(id, 320, 400, 1, 1, 0, 0, 0, ALL));
        probe = 1'b1;
        @(negedge pxl_clk); #1;
        probe = 1'b0;
        repeat (2) @(posedge pxl_clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin : driver
        checks          = 0;
        errors          = 0;
        probe           = 1'b0;
        reset_n         = 1'b0;
        bus.vsync       = 1'b0;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.h_collision = 1'b0;
        bus.v_collision = 1'b0;
        repeat (3) @(posedge pxl_clk);
        #1 reset_n = 1'b1;
        probe_chk(mk(0, 320, 400, 1, 1, 0, 0, 0, ALL));

        // idle frames: ball parked
        for (int k = 1; k <= 5; k++) frame(0, 0, 0, mk(10 + k, 320, 400, 1, 1, 0, 0, 0, ALL));

        // launch, fall to the miss line, serve restored
        launch();
        probe_chk(mk(20, 320, 400, 1, 1, 1, 0, 0, ALL));
        for (int k = 1; k <= 7; k++)
            frame(0, 0, 0, mk(20 + k, 320 + 5 * k, 400 + 10 * k, 1, 1, 1, 0, 0, ALL));
        frame(0, 0, 0, mk(28, 360, 472, 0, 0, 0, 1, 0, M_X | M_Y | M_MV | M_MS));
        probe_chk(mk(29, 320, 400, 1, 1, 0, 0, 0, ALL));

        // two v pulses in one frame give one flip; climb to the top wall
        launch();
        frame(0, 0, 0, mk(31, 325, 410, 1, 1, 1, 0, 0, ALL));
        frame(0, 0, 0, mk(32, 330, 420, 1, 1, 1, 0, 0, ALL));
        pulse_coll(0, 1);
        repeat (2) @(posedge pxl_clk);
        pulse_coll(0, 1);
        frame(0, 0, 0, mk(33, 335, 410, 1, 0, 1, 0, 0, ALL));
        for (int k = 1; k <= 40; k++)
            frame(0, 0, 0, mk(100 + k, 0, 410 - 10 * k, 0, 0, 0, 0, 0, M_Y | M_DY));
        frame(0, 0, 0, mk(34, 0, 8, 0, 1, 1, 0, 0, M_Y | M_DY | M_MV));
        mid_reset(40);

        // h and v in one frame, then a collision coincident with the tick
        launch();
        frame(0, 0, 0, mk(51, 325, 410, 1, 1, 1, 0, 0, ALL));
        frame(0, 0, 0, mk(52, 330, 420, 1, 1, 1, 0, 0, ALL));
        pulse_coll(1, 0);
        repeat (3) @(posedge pxl_clk);
        pulse_coll(0, 1);
        frame(0, 0, 0, mk(53, 325, 410, 0, 0, 1, 0, 0, ALL));
        frame(0, 1, 0, mk(54, 320, 420, 0, 1, 1, 0, 0, ALL));

        // pause together with a tick: tick processed, then frozen
        frame(0, 0, 1, mk(60, 315, 430, 0, 1, 1, 0, 0, ALL));
        probe_chk(mk(61, 315, 430, 0, 1, 0, 0, 0, ALL));
        frame(0, 0, 1, mk(62, 315, 430, 0, 1, 0, 0, 0, ALL));
        pulse_coll(1, 0);
        frame(0, 0, 1, mk(63, 315, 430, 0, 1, 0, 0, 0, ALL));
        frame(0, 0, 1, mk(64, 315, 430, 0, 1, 0, 0, 0, ALL));
        @(posedge pxl_clk); #1 bus.pause = 1'b0;
        repeat (2) @(posedge pxl_clk);
        frame(0, 0, 0, mk(65, 320, 440, 1, 1, 1, 0, 0, ALL));
        frame(0, 0, 0, mk(66, 325, 450, 1, 1, 1, 0, 0, ALL));
        frame(0, 0, 0, mk(67, 330, 460, 1, 1, 1, 0, 0, ALL));
        frame(0, 0, 0, mk(68, 335, 470, 1, 1, 1, 0, 0, ALL));
        frame(0, 0, 0, mk(69, 340, 472, 0, 0, 0, 1, 0, M_X | M_Y | M_MV | M_MS));
        probe_chk(mk(70, 320, 400, 1, 1, 0, 0, 0, ALL));

`ifdef BALL_SPEEDUP_EN
        // four paddle hits raise speed to 1; steps become 6/12; miss clears it
        launch();
        frame(0, 0, 0, mk(80, 325, 410, 1, 1, 1, 0, 0, ALL));
        for (int j = 1; j <= 7; j++)
            frame(0, 1, 0, mk(80 + j, 325 + 5 * j, (j % 2 == 1) ? 400 : 410, 1,
                              (j % 2 == 1) ? 0 : 1, 1, 0, (j == 7) ? 1 : 0, ALL));
        frame(0, 0, 0, mk(90, 366, 388, 1, 0, 1, 0, 1, ALL));
        frame(0, 0, 0, mk(91, 372, 376, 1, 0, 1, 0, 1, ALL));
        frame(0, 1, 0, mk(92, 378, 388, 1, 1, 1, 0, 1, ALL));
        for (int k = 1; k <= 7; k++)
            frame(0, 0, 0, mk(200 + k, 0, 388 + 12 * k, 0, 0, 0, (k == 7) ? 1 : 0, 1,
                              M_Y | M_MS | M_SP));
        probe_chk(mk(93, 320, 400, 1, 1, 0, 0, 0, ALL));
        launch();
        frame(0, 1, 0, mk(94, 325, 400, 1, 0, 1, 0, 0, ALL));
        mid_reset(95);
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge pxl_clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
